// File: rtl/abr_params_pkg.sv
// Shared ML-DSA algorithm parameters used across the signing datapath.
package abr_params_pkg;
    localparam int MLDSA_K = 8;
    localparam int MLDSA_N = 256;
endpackage

// File: rtl/decompose_defines_pkg.sv
// Types and sizing for the decompose w1 encoder: FSM states and per-operation beat/word counts.
package decompose_defines_pkg;
    localparam int W1_COEFF_W         = 4;
    localparam int W1_COEFF_PER_BEAT  = 4;
    localparam int W1_OUT_W           = 64;
    localparam int W1_FIFO_DEPTH      = 4;
    localparam int W1_BEAT_W          = W1_COEFF_W * W1_COEFF_PER_BEAT;
    localparam int W1_TOTAL_BEATS     = abr_params_pkg::MLDSA_K * (abr_params_pkg::MLDSA_N / 4);
    localparam int W1_TOTAL_WORDS     = W1_TOTAL_BEATS * W1_COEFF_PER_BEAT * W1_COEFF_W / W1_OUT_W;
    localparam int W1_BEAT_CNT_W      = $clog2(W1_TOTAL_BEATS + 1);
    localparam int W1_WORD_CNT_W      = $clog2(W1_TOTAL_WORDS);

    typedef enum logic [1:0] {
        W1ENC_IDLE   = 2'd0,
        W1ENC_ACTIVE = 2'd1,
        W1ENC_DRAIN  = 2'd2
    } w1enc_state_e;
endpackage

// File: rtl/abr_sync_fifo.sv
// Synchronous pointer FIFO; head visible combinationally (0 when empty), push lands next cycle.
// Push+pop together is legal even when full; a push into a full FIFO without a pop is dropped.
module abr_sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             zeroize,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign pop_data = empty ? '0 : mem_q[rd_ptr_q];
    assign do_pop   = pop && !empty;
    // At full the write slot equals the head being popped, so the overwrite is safe.
    assign do_push  = push && (!full || do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (zeroize) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

// File: rtl/decompose_w1_encode.sv
// Packs 4-bit w1 coefficients into 64-bit words for Keccak; word valid 1 cycle after its 4th beat.
// Upstream cannot stall: output backpressure is absorbed by a 4-word FIFO, overflow is flagged sticky.
module decompose_w1_encode
    import decompose_defines_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 zeroize,
    input  logic                 w1_enable,
    input  logic                 w1_valid_i,
    input  logic [W1_BEAT_W-1:0] w1_data_i,
    output logic [W1_OUT_W-1:0]  w1_data_o,
    output logic                 w1_valid_o,
    input  logic                 w1_ready_i,
    output logic                 w1_done,
    output logic                 overflow_err
);
    localparam int PACK_W = W1_OUT_W - W1_BEAT_W;

    w1enc_state_e               state_q, state_d;
    logic [W1_BEAT_CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic [W1_WORD_CNT_W-1:0]   word_cnt_q, word_cnt_d;
    logic [PACK_W-1:0]          pack_q, pack_d;
    logic                       overflow_q, overflow_d;

    logic [1:0]                 beat_idx;
    logic                       beat_acc;
    logic                       push;
    logic                       pop;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic [W1_OUT_W-1:0]        push_word;

    assign beat_idx     = beat_cnt_q[1:0];
    assign beat_acc     = (state_q == W1ENC_ACTIVE) && w1_valid_i;
    assign push         = beat_acc && (beat_idx == 2'd3);
    // The 4th beat bypasses the pack register and completes the word directly.
    assign push_word    = {w1_data_i, pack_q};
    assign w1_valid_o   = !fifo_empty;
    assign pop          = w1_valid_o && w1_ready_i;
    assign w1_done      = pop && (state_q == W1ENC_DRAIN)
                          && (word_cnt_q == W1_WORD_CNT_W'(W1_TOTAL_WORDS - 1));
    assign overflow_err = overflow_q;

    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        word_cnt_d = word_cnt_q;
        pack_d     = pack_q;
        overflow_d = overflow_q;

        if (pop) begin
            word_cnt_d = word_cnt_q + 1'b1;
        end
        if (push && fifo_full && !pop) begin
            overflow_d = 1'b1;
        end

        case (state_q)
            W1ENC_IDLE: begin
                if (w1_enable) begin
                    state_d    = W1ENC_ACTIVE;
                    beat_cnt_d = '0;
                    word_cnt_d = '0;
                    pack_d     = '0;
                    overflow_d = 1'b0;
                end
            end
            W1ENC_ACTIVE: begin
                if (beat_acc) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    case (beat_idx)
                        2'd0:    pack_d[0*W1_BEAT_W +: W1_BEAT_W] = w1_data_i;
                        2'd1:    pack_d[1*W1_BEAT_W +: W1_BEAT_W] = w1_data_i;
                        2'd2:    pack_d[2*W1_BEAT_W +: W1_BEAT_W] = w1_data_i;
                        default: pack_d = pack_q;
                    endcase
                    if (beat_cnt_q == W1_BEAT_CNT_W'(W1_TOTAL_BEATS - 1)) begin
                        state_d = W1ENC_DRAIN;
                    end
                end
            end
            W1ENC_DRAIN: begin
                if (w1_done) begin
                    state_d = W1ENC_IDLE;
                end
            end
            default: state_d = W1ENC_IDLE;
        endcase

        if (zeroize) begin
            state_d    = W1ENC_IDLE;
            beat_cnt_d = '0;
            word_cnt_d = '0;
            pack_d     = '0;
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= W1ENC_IDLE;
            beat_cnt_q <= '0;
            word_cnt_q <= '0;
            pack_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            word_cnt_q <= word_cnt_d;
            pack_q     <= pack_d;
            overflow_q <= overflow_d;
        end
    end

    abr_sync_fifo #(
        .WIDTH (W1_OUT_W),
        .DEPTH (W1_FIFO_DEPTH)
    ) u_out_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .zeroize   (zeroize),
        .push      (push),
        .push_data (push_word),
        .pop       (pop),
        .pop_data  (w1_data_o),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );
endmodule

// File: tb/tb_decompose_w1_encode.sv
// Directed bench for decompose_w1_encode: streaming, backpressure, overflow, zeroize, ignored controls.
module tb_decompose_w1_encode;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        zeroize;
    logic        w1_enable;
    logic        w1_valid_i;
    logic [15:0] w1_data_i;
    logic [63:0] w1_data_o;
    logic        w1_valid_o;
    logic        w1_ready_i;
    logic        w1_done;
    logic        overflow_err;

    int checks   = 0;
    int failures = 0;

    logic [63:0] exp_q [$];
    int          pop_cnt;
    int          done_cnt;
    int          done_at;
    logic [63:0] first_word;
    logic [63:0] last_word;

    always #5 clk = ~clk;

    decompose_w1_encode dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .zeroize      (zeroize),
        .w1_enable    (w1_enable),
        .w1_valid_i   (w1_valid_i),
        .w1_data_i    (w1_data_i),
        .w1_data_o    (w1_data_o),
        .w1_valid_o   (w1_valid_o),
        .w1_ready_i   (w1_ready_i),
        .w1_done      (w1_done),
        .overflow_err (overflow_err)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Output monitor: every accepted word is compared against the expected queue in order.
    always @(negedge clk) begin
        if (reset_n) begin
            if (w1_valid_o && w1_ready_i) begin
                if (pop_cnt == 0) first_word = w1_data_o;
                last_word = w1_data_o;
                if (exp_q.size() > 0) check_eq("pop_word", w1_data_o, exp_q.pop_front());
                pop_cnt++;
            end
            if (w1_done) begin
                done_cnt++;
                done_at = pop_cnt;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        w1_valid_i = 1'b0;
        w1_enable  = 1'b0;
        zeroize    = 1'b0;
    endtask

    task automatic beat(input logic [15:0] d);
        w1_valid_i = 1'b1;
        w1_data_i  = d;
        step();
    endtask

    task automatic start_op();
        w1_enable = 1'b1;
        step();
    endtask

    task automatic clear_mon();
        exp_q.delete();
        pop_cnt    = 0;
        done_cnt   = 0;
        done_at    = -1;
        first_word = '0;
        last_word  = '0;
    endtask

    function automatic logic [15:0] gdat(input int n);
        return 16'((n * 37) ^ 32'h5A5A);
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        int c;
        int saved;

        reset_n    = 1'b0;
        zeroize    = 1'b0;
        w1_enable  = 1'b0;
        w1_valid_i = 1'b0;
        w1_data_i  = '0;
        w1_ready_i = 1'b0;
        clear_mon();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        check_eq("rst_valid", 64'(w1_valid_o), 64'd0);
        check_eq("rst_data", w1_data_o, 64'd0);
        check_eq("rst_done", 64'(w1_done), 64'd0);
        check_eq("rst_ovf", 64'(overflow_err), 64'd0);
        step();

        // Sequential stream, always ready.
        clear_mon();
        for (int w = 0; w < 128; w++)
            exp_q.push_back({16'(4*w+3), 16'(4*w+2), 16'(4*w+1), 16'(4*w)});
        w1_ready_i = 1'b1;
        start_op();
        for (int i = 0; i < 512; i++) beat(16'(i));
        for (int i = 0; i < 20 && done_cnt == 0; i++) step();
        check_eq("seq_pops", 64'(pop_cnt), 64'd128);
        check_eq("seq_done_cnt", 64'(done_cnt), 64'd1);
        check_eq("seq_done_at", 64'(done_at), 64'd128);
        check_eq("seq_word0", first_word, 64'h0003_0002_0001_0000);
        check_eq("seq_word127", last_word, 64'h01FF_01FE_01FD_01FC);
        check_eq("seq_ovf", 64'(overflow_err), 64'd0);

        // Backpressure, then overflow with the 5th word dropped.
        clear_mon();
        w1_ready_i = 1'b0;
        start_op();
        for (int i = 0; i < 16; i++) begin
            beat(16'h1000 + 16'(i));
            if (i == 2) check_eq("lat_before", 64'(w1_valid_o), 64'd0);
            if (i == 3) check_eq("lat_after", 64'(w1_valid_o), 64'd1);
        end
        check_eq("bp_valid", 64'(w1_valid_o), 64'd1);
        check_eq("bp_head", w1_data_o, 64'h1003_1002_1001_1000);
        check_eq("bp_ovf_pre", 64'(overflow_err), 64'd0);
        repeat (3) step();
        check_eq("bp_stable", w1_data_o, 64'h1003_1002_1001_1000);
        for (int i = 16; i < 20; i++) beat(16'h1000 + 16'(i));
        check_eq("bp_ovf_set", 64'(overflow_err), 64'd1);
        exp_q.push_back(64'h1003_1002_1001_1000);
        exp_q.push_back(64'h1007_1006_1005_1004);
        exp_q.push_back(64'h100B_100A_1009_1008);
        exp_q.push_back(64'h100F_100E_100D_100C);
        w1_ready_i = 1'b1;
        repeat (8) step();
        check_eq("bp_pops", 64'(pop_cnt), 64'd4);
        check_eq("bp_empty", 64'(w1_valid_o), 64'd0);
        check_eq("bp_ovf_sticky", 64'(overflow_err), 64'd1);
        check_eq("bp_no_done", 64'(done_cnt), 64'd0);
        zeroize = 1'b1;
        step();
        check_eq("zero_ovf", 64'(overflow_err), 64'd0);
        check_eq("zero_valid", 64'(w1_valid_o), 64'd0);

        // Push and pop in the same cycle while full.
        clear_mon();
        w1_ready_i = 1'b0;
        start_op();
        for (int i = 0; i < 19; i++) beat(16'h2000 + 16'(i));
        exp_q.push_back(64'h2003_2002_2001_2000);
        exp_q.push_back(64'h2007_2006_2005_2004);
        exp_q.push_back(64'h200B_200A_2009_2008);
        exp_q.push_back(64'h200F_200E_200D_200C);
        exp_q.push_back(64'h2013_2012_2011_2010);
        w1_ready_i = 1'b1;
        beat(16'h2013);
        w1_ready_i = 1'b0;
        check_eq("pp_ovf", 64'(overflow_err), 64'd0);
        check_eq("pp_one_pop", 64'(pop_cnt), 64'd1);
        w1_ready_i = 1'b1;
        repeat (8) step();
        check_eq("pp_pops", 64'(pop_cnt), 64'd5);
        check_eq("pp_empty", 64'(w1_valid_o), 64'd0);
        zeroize = 1'b1;
        step();

        // Gapped input with ready toggling every 3 cycles.
        clear_mon();
        for (int w = 0; w < 128; w++)
            exp_q.push_back({gdat(4*w+3), gdat(4*w+2), gdat(4*w+1), gdat(4*w)});
        start_op();
        n = 0;
        c = 0;
        while (n < 512 && c < 4000) begin
            w1_ready_i = ((c / 3) % 2 == 0);
            if (c % 2 == 0) begin
                beat(gdat(n));
                n++;
            end else begin
                step();
            end
            c++;
        end
        check_eq("gap_beats", 64'(n), 64'd512);
        while (done_cnt == 0 && c < 5000) begin
            w1_ready_i = ((c / 3) % 2 == 0);
            step();
            c++;
        end
        check_eq("gap_pops", 64'(pop_cnt), 64'd128);
        check_eq("gap_done_cnt", 64'(done_cnt), 64'd1);
        check_eq("gap_done_at", 64'(done_at), 64'd128);
        check_eq("gap_ovf", 64'(overflow_err), 64'd0);

        // Back in IDLE: valid beats must be ignored.
        w1_ready_i = 1'b1;
        saved = pop_cnt;
        for (int i = 0; i < 8; i++) beat(16'hFFFF);
        repeat (3) step();
        check_eq("idle_no_pop", 64'(pop_cnt), 64'(saved));
        check_eq("idle_valid", 64'(w1_valid_o), 64'd0);

        // Zeroize mid-run with 4 words buffered and 2 beats in the pack register.
        clear_mon();
        for (int w = 0; w < 46; w++)
            exp_q.push_back({16'(4*w+3), 16'(4*w+2), 16'(4*w+1), 16'(4*w)});
        w1_ready_i = 1'b1;
        start_op();
        for (int i = 0; i < 202; i++) begin
            if (i == 185) w1_ready_i = 1'b0;
            beat(16'(i));
        end
        check_eq("zm_pops", 64'(pop_cnt), 64'd46);
        check_eq("zm_valid_pre", 64'(w1_valid_o), 64'd1);
        zeroize = 1'b1;
        step();
        check_eq("zm_valid_post", 64'(w1_valid_o), 64'd0);
        check_eq("zm_no_done", 64'(done_cnt), 64'd0);

        // Fresh operation; w1_enable mid-word must not restart packing.
        clear_mon();
        exp_q.push_back(64'hB003_B002_B001_B000);
        w1_ready_i = 1'b1;
        start_op();
        beat(16'hB000);
        beat(16'hB001);
        w1_enable = 1'b1;
        step();
        beat(16'hB002);
        beat(16'hB003);
        repeat (3) step();
        check_eq("fresh_pops", 64'(pop_cnt), 64'd1);
        check_eq("fresh_word", first_word, 64'hB003_B002_B001_B000);
        check_eq("fresh_empty", 64'(w1_valid_o), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/decompose_w1_encode.md
Name: decompose_w1_encode

Overview:
- Stage directly downstream of the decompose mod-2gamma2 datapath.
- Consumes the w1 (high-bits) coefficients produced while the decompose controller streams all MLDSA_K polynomials.
- Packs them per ML-DSA w1Encode (4 bits/coeff, gamma2=(q-1)/32) into 64-bit words.
- Buffers the words in a small FIFO and hands them to the Keccak SIPO under valid/ready; the upstream side has no stall, so the block absorbs jitter and flags overflow.

Parameters:
- COEFF_W, 4, bits per w1 coefficient.
- COEFF_PER_BEAT, 4, coefficients per input beat (one memory address worth).
- OUT_W, 64, output word width.
- FIFO_DEPTH, 4, output words buffered (power of two).
- TOTAL_BEATS, MLDSA_K*(MLDSA_N/4) = 512, input beats per operation.
- TOTAL_WORDS, TOTAL_BEATS*COEFF_PER_BEAT*COEFF_W/OUT_W = 128, output words per operation.

Ports:
- clk  input  1  clock
- reset_n  input  1  asynchronous active-low reset
- zeroize  input  1  synchronous clear of all state, priority over everything but reset
- w1_enable  input  1  start pulse; accepted only in IDLE
- w1_valid_i  input  1  one beat of 4 coefficients present this cycle
- w1_data_i  input  16  coeff j in bits [4j+3:4j], j=0..3, coeff 0 lowest index
- w1_data_o  output  64  packed word to Keccak (FIFO head)
- w1_valid_o  output  1  FIFO not empty
- w1_ready_i  input  1  Keccak accepts word when valid&ready
- w1_done  output  1  one-cycle pulse when word TOTAL_WORDS-1 is popped
- overflow_err  output  1  sticky; push attempted while FIFO full and no pop

Behaviour:
- Reset/zeroize values: all outputs 0, FSM IDLE, all counters 0, FIFO empty, pack register 0, overflow_err 0.
- FSM states:
  - IDLE -> ACTIVE on w1_enable; clears beat counter, word counter, pack register and overflow_err.
  - ACTIVE -> DRAIN when the accepted beat count reaches TOTAL_BEATS.
  - DRAIN -> IDLE in the cycle the final word is popped; w1_done pulses in that same cycle (combinational on the pop).
- w1_enable in ACTIVE/DRAIN: ignored.
- w1_valid_i outside ACTIVE: ignored; no count, no pack.
- Packing:
  - 2-bit beat-in-word index b; beat occupies pack[16b+15:16b]; first coefficient of each word sits in bits [3:0] (little-endian, spec byte order).
  - On the beat with b==3, the completed word (pack[47:0] plus the current beat in [63:48]) is pushed into the FIFO in the same cycle.
  - Latency from the 4th beat to w1_valid_o: 1 cycle.
- FIFO:
  - Pointer-based, with FIFO_DEPTH+1-state occupancy counter.
  - Push and pop in the same cycle are legal at any occupancy, including full; occupancy is unchanged.
  - Push when full with no pop: word dropped, overflow_err set and held until the next w1_enable or zeroize; the beat counter still advances so the operation terminates.
  - Pop when empty: impossible, since w1_valid_o is 0.
  - w1_data_o stays stable while valid and not ready.
- Word counter: 7 bits, increments on each pop; compared against TOTAL_WORDS-1 for done. No wrap within one operation.
- Zeroize or reset mid-operation: abandons the operation immediately, discards FIFO contents, no w1_done.

Decomposition:
- decompose_defines_pkg:
  - w1enc_state_e {W1ENC_IDLE, W1ENC_ACTIVE, W1ENC_DRAIN}
  - localparams W1_COEFF_W, W1_TOTAL_BEATS, W1_TOTAL_WORDS, derived from MLDSA_K and MLDSA_N in abr_params_pkg.
- One sub-module, abr_sync_fifo: parameterised width/depth, zeroize, full/empty, same-cycle push+pop. Packing and FSM stay in the top.

Test Plan:
- Sequential beats, ready=1: enable, 512 consecutive beats with beat n data = n[15:0] -> word 0 = 0x0003_0002_0001_0000, word 127 = 0x01FF_01FE_01FD_01FC; 128 pops; w1_done pulses once with the last pop; overflow_err=0.
- Ready=0 backpressure: 16 beats with ready=0 -> exactly 4 words buffered, valid=1, data stable. 4 more beats -> overflow_err=1, 5th word dropped; then ready=1 -> the 4 buffered words emerge in order.
- Simultaneous push/pop at full: FIFO full, ready=1 on the cycle the 4th beat of the next word arrives -> no overflow, occupancy stays 4, order preserved.
- Gapped input: w1_valid_i toggling 1/0 with ready toggling every 3 cycles -> all 128 words correct; done only after the final pop; state then IDLE.
- Zeroize mid-run: assert after 200 beats -> w1_valid_o=0 next cycle, no done. Fresh enable then produces word 0 from new data, not from stale pack bits.
- Ignored controls: w1_enable during ACTIVE and w1_valid_i while IDLE -> no counter change, no extra words.
